mem_responder: RTL and testbench

- Single-clock memory model that answers the core's instruction port (read-only) and data port (read/write with byte enables).
- Backed by one single-ported word array.
- A round-robin arbiter grants one access at a time, and the granted access completes after a fixed, parameterised latency.
- Serves as the memory side of the core's imem/dmem request/response handshake, for simulation and FPGA bring-up.

---
 rtl/mem_responder_pkg.sv | 25 ++
 rtl/mem_resp_array.sv | 55 +++++
 rtl/mem_responder.sv | 143 ++++++++++++++
 tb/tb_mem_responder.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared types for mem_responder: FSM states, port ids and the latched request payload.
package mem_responder_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned LFSR_W = 8;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} mem_resp_state_t;
  typedef enum logic {IMEM, DMEM} mem_port_t;

  typedef struct packed {
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
    logic              is_write;
    mem_port_t         port;
  } mem_req_t;

  // Fibonacci LFSR step, taps 8,6,5,4
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

endpackage

// File: rtl/mem_resp_array.sv
// Single-port DEPTH x 32 word store with byte-lane writes and a held, registered
// read result per destination port.
module mem_resp_array
  import mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     we,
  input  logic [BE_W-1:0]          be,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DATA_W-1:0]        wdata,
  input  mem_port_t                dst,
  output logic [DATA_W-1:0]        imem_rdata,
  output logic [DATA_W-1:0]        dmem_rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] imem_rdata_d, imem_rdata_q;
  logic [DATA_W-1:0] dmem_rdata_d, dmem_rdata_q;

  // Storage is never reset; a reset cycle suppresses the write.
  always_ff @(posedge clk) begin
    if (rst && en && we) begin
      for (int i = 0; i < int'(BE_W); i++) begin
        if (be[i]) mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    imem_rdata_d = imem_rdata_q;
    dmem_rdata_d = dmem_rdata_q;
    if (en && !we) begin
      if (dst == IMEM) imem_rdata_d = mem_q[addr];
      else             dmem_rdata_d = mem_q[addr];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      imem_rdata_q <= '0;
      dmem_rdata_q <= '0;
    end else begin
      imem_rdata_q <= imem_rdata_d;
      dmem_rdata_q <= dmem_rdata_d;
    end
  end

  assign imem_rdata = imem_rdata_q;
  assign dmem_rdata = dmem_rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory responder for the core's imem/dmem ports: round-robin arbiter, fixed-latency FSM.
// Optional MEM_RESPONDER_JITTER_EN adds 0..3 LFSR-driven wait cycles per access.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] imem_addr,
  input  logic              imem_read,
  output logic [DATA_W-1:0] imem_rdata,
  output logic              imem_resp,
  input  logic [DATA_W-1:0] dmem_addr,
  input  logic              dmem_read,
  input  logic              dmem_write,
  input  logic [BE_W-1:0]   dmem_byte_enable,
  input  logic [DATA_W-1:0] dmem_wdata,
  output logic [DATA_W-1:0] dmem_rdata,
  output logic              dmem_resp,
  output logic              busy
);

  localparam int unsigned AW = $clog2(DEPTH);

  mem_resp_state_t state_d, state_q;
  mem_req_t        req_d, req_q;
  mem_port_t       last_grant_d, last_grant_q;
  mem_port_t       grant;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic            imem_resp_d, imem_resp_q;
  logic            dmem_resp_d, dmem_resp_q;
  logic            busy_d, busy_q;
  logic            mem_en_c;
  logic            imem_req, dmem_req;
  logic            unused_addr_bits;

`ifdef MEM_RESPONDER_JITTER_EN
  logic [LFSR_W-1:0] lfsr_d, lfsr_q;
`endif

  assign imem_req = imem_read;
  assign dmem_req = dmem_read | dmem_write;

  // Next-state, grant and latch logic; the array fires on the edge entering RESP.
  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    grant        = IMEM;
`ifdef MEM_RESPONDER_JITTER_EN
    lfsr_d       = lfsr_q;
`endif
    case (state_q)
      IDLE: begin
        if (imem_req || dmem_req) begin
          if (imem_req && dmem_req) grant = (last_grant_q == IMEM) ? DMEM : IMEM;
          else                      grant = dmem_req ? DMEM : IMEM;
          last_grant_d = grant;
          req_d.port   = grant;
          if (grant == DMEM) begin
            req_d.addr     = dmem_addr;
            req_d.wdata    = dmem_wdata;
            req_d.be       = dmem_byte_enable;
            req_d.is_write = dmem_write;
          end else begin
            req_d.addr     = imem_addr;
            req_d.wdata    = '0;
            req_d.be       = '0;
            req_d.is_write = 1'b0;
          end
`ifdef MEM_RESPONDER_JITTER_EN
          cnt_d  = CNT_W'(LATENCY - 1) + CNT_W'(lfsr_q[1:0]);
          lfsr_d = lfsr_step(lfsr_q);
`else
          cnt_d  = CNT_W'(LATENCY - 1);
`endif
          state_d = (cnt_d == '0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    mem_en_c    = (state_d == RESP);
    imem_resp_d = mem_en_c && (req_d.port == IMEM);
    dmem_resp_d = mem_en_c && (req_d.port == DMEM);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      req_q        <= '0;
      cnt_q        <= '0;
      last_grant_q <= IMEM;
      imem_resp_q  <= 1'b0;
      dmem_resp_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      imem_resp_q  <= imem_resp_d;
      dmem_resp_q  <= dmem_resp_d;
      busy_q       <= busy_d;
    end
  end

`ifdef MEM_RESPONDER_JITTER_EN
  always_ff @(posedge clk) begin
    if (!rst) lfsr_q <= LFSR_W'(1);
    else      lfsr_q <= lfsr_d;
  end
`endif

  // Word index only; byte offset and bits above the array alias away.
  assign unused_addr_bits = ^{req_q.addr[DATA_W-1:AW+2], req_q.addr[1:0]};

  mem_resp_array #(.DEPTH(DEPTH)) u_array (
    .clk        (clk),
    .rst        (rst),
    .en         (mem_en_c),
    .we         (req_d.is_write),
    .be         (req_d.be),
    .addr       (req_d.addr[AW+1:2]),
    .wdata      (req_d.wdata),
    .dst        (req_d.port),
    .imem_rdata (imem_rdata),
    .dmem_rdata (dmem_rdata)
  );

  assign imem_resp = imem_resp_q;
  assign dmem_resp = dmem_resp_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder (LATENCY=2 main instance, LATENCY=1 side instance).
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr, dmem_addr, dmem_wdata;
  logic        imem_read, dmem_read, dmem_write;
  logic [3:0]  dmem_byte_enable;
  logic [31:0] imem_rdata, dmem_rdata;
  logic        imem_resp, dmem_resp, busy;

  logic [31:0] i1_addr;
  logic        i1_read;
  logic [31:0] z32 = 32'h0;
  logic        z1 = 1'b0;
  logic [3:0]  z4 = 4'h0;
  logic [31:0] i1_rdata, d1_rdata;
  logic        i1_resp, d1_resp, busy1;

  int checks = 0;
  int failures = 0;
  int n;
  int total;

  always #5 clk = ~clk;

  mem_responder #(.DEPTH(1024), .LATENCY(2)) u_dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_read(imem_read), .imem_rdata(imem_rdata), .imem_resp(imem_resp),
    .dmem_addr(dmem_addr), .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_byte_enable(dmem_byte_enable), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp), .busy(busy)
  );

  mem_responder #(.DEPTH(1024), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .imem_addr(i1_addr), .imem_read(i1_read), .imem_rdata(i1_rdata), .imem_resp(i1_resp),
    .dmem_addr(z32), .dmem_read(z1), .dmem_write(z1),
    .dmem_byte_enable(z4), .dmem_wdata(z32),
    .dmem_rdata(d1_rdata), .dmem_resp(d1_resp), .busy(busy1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Counts edges until the selected resp is seen, bounded at 20.
  task automatic wait_resp(input bit is_d, output int cnt);
    cnt = 0;
    do begin
      @(posedge clk); #1;
      cnt++;
    end while (!(is_d ? dmem_resp : imem_resp) && cnt < 20);
  endtask

  task automatic dmem_op(input logic [31:0] a, input logic w, input logic [3:0] be,
                         input logic [31:0] wd, input logic [31:0] exp_rd,
                         input bit chk_rd, input string tag);
    int lat;
    dmem_addr = a; dmem_write = w; dmem_read = !w; dmem_byte_enable = be; dmem_wdata = wd;
    wait_resp(1'b1, lat);
    check({tag, " latency"}, 32'(lat), 32'd2);
    if (chk_rd) check({tag, " rdata"}, dmem_rdata, exp_rd);
    dmem_read = 1'b0; dmem_write = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic imem_op(input logic [31:0] a, input logic [31:0] exp_rd, input string tag);
    int lat;
    imem_addr = a; imem_read = 1'b1;
    wait_resp(1'b0, lat);
    check({tag, " latency"}, 32'(lat), 32'd2);
    check({tag, " rdata"}, imem_rdata, exp_rd);
    imem_read = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    imem_addr = '0; imem_read = 1'b0;
    dmem_addr = '0; dmem_read = 1'b0; dmem_write = 1'b0; dmem_byte_enable = '0; dmem_wdata = '0;
    i1_addr = '0; i1_read = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst imem_resp", 32'(imem_resp), 32'd0);
    check("rst dmem_resp", 32'(dmem_resp), 32'd0);
    check("rst imem_rdata", imem_rdata, 32'h0);
    check("rst dmem_rdata", dmem_rdata, 32'h0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst busy1", 32'(busy1), 32'd0);
    rst = 1'b1;

    // First tie after reset goes to dmem, imem follows one access later
    imem_addr = 32'h40; imem_read = 1'b1;
    dmem_addr = 32'h44; dmem_read = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(imem_resp || dmem_resp) && n < 20);
    check("tie0 latency", 32'(n), 32'd2);
    check("tie0 dmem_resp", 32'(dmem_resp), 32'd1);
    check("tie0 imem_resp", 32'(imem_resp), 32'd0);
    dmem_read = 1'b0;
    wait_resp(1'b0, n);
    total = n + 2;
    check("tie0 imem latency", 32'(total), 32'd5);

    // Ten back-to-back alternating pairs with both requests held
    dmem_read = 1'b1;
    for (int k = 0; k < 20; k++) begin
      n = 0;
      do begin
        @(posedge clk); #1;
        n++;
      end while (!(imem_resp || dmem_resp) && n < 10);
      check("rr spacing", 32'(n), 32'd3);
      check("rr dmem_resp", 32'(dmem_resp), (k % 2 == 0) ? 32'd1 : 32'd0);
      check("rr imem_resp", 32'(imem_resp), (k % 2 == 1) ? 32'd1 : 32'd0);
    end
    imem_read = 1'b0; dmem_read = 1'b0;
    @(posedge clk); #1;

    // Write then read back
    dmem_op(32'h40, 1'b1, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0, "wr40");
    dmem_op(32'h40, 1'b0, 4'h0, 32'h0, 32'hDEADBEEF, 1'b1, "rd40");
    imem_op(32'h40, 32'hDEADBEEF, "ird40");

    // Byte lanes; writes leave dmem_rdata untouched
    dmem_op(32'h10, 1'b1, 4'hF, 32'h11223344, 32'hDEADBEEF, 1'b1, "wr10");
    dmem_op(32'h10, 1'b1, 4'b0101, 32'hAABBCCDD, 32'hDEADBEEF, 1'b1, "wr10 be5");
    dmem_op(32'h10, 1'b0, 4'h0, 32'h0, 32'h11BB33DD, 1'b1, "rd10");
    dmem_op(32'h10, 1'b1, 4'h0, 32'hFFFFFFFF, 32'h11BB33DD, 1'b1, "wr10 be0");
    dmem_op(32'h10, 1'b0, 4'h0, 32'h0, 32'h11BB33DD, 1'b1, "rd10 after be0");

    // Aliasing modulo DEPTH*4 and ignored byte offset
    dmem_op(32'h1000, 1'b1, 4'hF, 32'h5A5A5A5A, 32'h11BB33DD, 1'b1, "wr1000");
    dmem_op(32'h0, 1'b0, 4'h0, 32'h0, 32'h5A5A5A5A, 1'b1, "rd0 alias");
    dmem_op(32'h3, 1'b0, 4'h0, 32'h0, 32'h5A5A5A5A, 1'b1, "rd3 alias");
    imem_op(32'hFFFFF000, 32'h5A5A5A5A, "ird alias");

    // Reset while a write sits in WAIT aborts it
    dmem_op(32'h80, 1'b1, 4'hF, 32'h12345678, 32'h5A5A5A5A, 1'b1, "wr80");
    dmem_addr = 32'h80; dmem_write = 1'b1; dmem_byte_enable = 4'hF; dmem_wdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    check("abort busy in wait", 32'(busy), 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;
    check("abort dmem_resp", 32'(dmem_resp), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    check("abort dmem_rdata", dmem_rdata, 32'h0);
    dmem_write = 1'b0;
    @(posedge clk); #1;
    check("abort dmem_resp late", 32'(dmem_resp), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    dmem_op(32'h80, 1'b0, 4'h0, 32'h0, 32'h12345678, 1'b1, "rd80 after abort");

    // Request dropped right after grant still completes, single-cycle pulse, rdata held
    dmem_addr = 32'h40; dmem_read = 1'b1;
    @(posedge clk); #1;
    check("drop resp early", 32'(dmem_resp), 32'd0);
    dmem_read = 1'b0;
    @(posedge clk); #1;
    check("drop resp", 32'(dmem_resp), 32'd1);
    check("drop rdata", dmem_rdata, 32'hDEADBEEF);
    @(posedge clk); #1;
    check("drop resp pulse", 32'(dmem_resp), 32'd0);
    check("drop rdata hold", dmem_rdata, 32'hDEADBEEF);

    // LATENCY=1 instance with a continuously held request
    i1_addr = 32'h0; i1_read = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      check("lat1 resp", 32'(i1_resp), (k % 2 == 1) ? 32'd1 : 32'd0);
      check("lat1 busy", 32'(busy1), (k % 2 == 1) ? 32'd1 : 32'd0);
    end
    i1_read = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
